// File: rtl/reduce_pkg.sv
// Shared types for the frame reduction stage: FSM state, flag triple and identity.
package reduce_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } red_state_t;

    typedef struct packed {
        logic and_f;
        logic or_f;
        logic xor_f;
    } red_flags_t;

    // Neutral element of the AND/OR/XOR reduction
    localparam red_flags_t RED_IDENTITY = '{and_f: 1'b1, or_f: 1'b0, xor_f: 1'b0};

endpackage

// File: rtl/frame_reduce_acc_if.sv
// Stream bus for frame_reduce_acc: input word stream plus per-frame result.
// Optional build macro: REDUCE_BEAT_COUNT_EN adds the out_beats field.
interface frame_reduce_acc_if #(
    parameter int unsigned W = 32
`ifdef REDUCE_BEAT_COUNT_EN
    , parameter int unsigned CNT_W = 8
`endif
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic         out_and;
    logic         out_or;
    logic         out_xor;
    logic         out_nand;
    logic         out_nor;
    logic         out_xnor;
`ifdef REDUCE_BEAT_COUNT_EN
    logic [CNT_W-1:0] out_beats;
`endif

    // Upstream source / downstream sink side
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_and, out_or, out_xor,
        input  out_nand, out_nor, out_xnor
`ifdef REDUCE_BEAT_COUNT_EN
        , input out_beats
`endif
    );

    // Reduction stage side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_and, out_or, out_xor,
        output out_nand, out_nor, out_xnor
`ifdef REDUCE_BEAT_COUNT_EN
        , output out_beats
`endif
    );

endinterface

// File: rtl/word_reduce.sv
// Folds one word's AND/OR/XOR reductions into a running flag triple.
module word_reduce
    import reduce_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] word,
    input  red_flags_t   prev,
    output red_flags_t   combined_c
);

    // Combine previous flags with this word's bit reductions
    always_comb begin
        combined_c       = RED_IDENTITY;
        combined_c.and_f = prev.and_f & (&word);
        combined_c.or_f  = prev.or_f  | (|word);
        combined_c.xor_f = prev.xor_f ^ (^word);
    end

endmodule

// File: rtl/frame_reduce_acc.sv
// Streaming per-frame AND/OR/XOR reduction with a single registered result slot.
// Optional build macro: REDUCE_BEAT_COUNT_EN adds a saturating beat counter (out_beats).
module frame_reduce_acc
    import reduce_pkg::*;
#(
    parameter int unsigned W = 32
`ifdef REDUCE_BEAT_COUNT_EN
    , parameter int unsigned CNT_W = 8
`endif
) (
    input logic               clk,
    input logic               rst_n,
    frame_reduce_acc_if.slave bus
);

    red_state_t state;
    red_flags_t acc;
    red_flags_t out_flags;
    red_flags_t prev_c;
    red_flags_t combined_c;
    logic       out_valid;
    logic       accept_c;
    logic       xfer_c;

    // One result slot: a new beat may enter whenever the slot is empty or draining
    assign bus.in_ready = !out_valid || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign xfer_c       = out_valid && bus.out_ready;

    // First beat of a frame starts from identity rather than the stale accumulator
    assign prev_c = (state == ACC) ? acc : RED_IDENTITY;

    word_reduce #(.W(W)) u_word_reduce (
        .word       (bus.in_data),
        .prev       (prev_c),
        .combined_c (combined_c)
    );

    // Frame FSM, accumulator and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= RED_IDENTITY;
            out_flags <= RED_IDENTITY;
            out_valid <= 1'b0;
        end else begin
            if (xfer_c) begin
                out_valid <= 1'b0;
            end
            if (accept_c) begin
                if (bus.in_last) begin
                    out_flags <= combined_c;
                    out_valid <= 1'b1;
                    acc       <= RED_IDENTITY;
                    state     <= IDLE;
                end else begin
                    acc   <= combined_c;
                    state <= ACC;
                end
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_and   = out_flags.and_f;
    assign bus.out_or    = out_flags.or_f;
    assign bus.out_xor   = out_flags.xor_f;
    assign bus.out_nand  = ~out_flags.and_f;
    assign bus.out_nor   = ~out_flags.or_f;
    assign bus.out_xnor  = ~out_flags.xor_f;

`ifdef REDUCE_BEAT_COUNT_EN
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_out;
    logic [CNT_W-1:0] cnt_next_c;

    // First beat counts as one; later beats increment and stick at all-ones
    assign cnt_next_c = (state == IDLE)  ? CNT_W'(1) :
                        (&beat_cnt)      ? beat_cnt  :
                                           beat_cnt + CNT_W'(1);

    // Beat counter and its per-frame snapshot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            beat_out <= '0;
        end else if (accept_c) begin
            if (bus.in_last) begin
                beat_out <= cnt_next_c;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= cnt_next_c;
            end
        end
    end

    assign bus.out_beats = beat_out;
`endif

endmodule

// File: tb/tb_frame_reduce_acc.sv
// Directed bench for frame_reduce_acc; build with REDUCE_BEAT_COUNT_EN to cover out_beats.
module tb_frame_reduce_acc;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

`ifdef REDUCE_BEAT_COUNT_EN
    frame_reduce_acc_if #(.W(32), .CNT_W(8)) bus ();
    frame_reduce_acc #(.W(32), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    frame_reduce_acc_if #(.W(32)) bus ();
    frame_reduce_acc #(.W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        total++; if ({bus.out_and, bus.out_or, bus.out_xor} !== 3'b100) begin bad++; $display("FAIL reset_flags: got %b want 100", {bus.out_and, bus.out_or, bus.out_xor}); end
        total++; if ({bus.out_nand, bus.out_nor, bus.out_xnor} !== 3'b011) begin bad++; $display("FAIL reset_compl: got %b want 011", {bus.out_nand, bus.out_nor, bus.out_xnor}); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single_ones();
        bus.out_ready = 1'b1;
        beat(32'hFFFF_FFFF, 1'b1);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        total++; if ({bus.out_and, bus.out_or, bus.out_xor, bus.out_xnor} !== 4'b1101) begin bad++; $display("FAIL single_flags: got %b want 1101", {bus.out_and, bus.out_or, bus.out_xor, bus.out_xnor}); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_two_beat();
        beat(32'h0000_0001, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL two_mid_valid: got %b want 0", bus.out_valid); end
        beat(32'h0000_0003, 1'b1);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL two_valid: got %b want 1", bus.out_valid); end
        total++; if ({bus.out_and, bus.out_or, bus.out_xor, bus.out_nand, bus.out_nor} !== 5'b01110) begin bad++; $display("FAIL two_flags: got %b want 01110", {bus.out_and, bus.out_or, bus.out_xor, bus.out_nand, bus.out_nor}); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        beat(32'h0000_00F0, 1'b1);
        total++; if ({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor} !== 4'b1010) begin bad++; $display("FAIL bp_first: got %b want 1010", {bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}); end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFF_FFFF;
        bus.in_last  = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b want 0", bus.in_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if ({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor} !== 4'b1010) begin bad++; $display("FAIL bp_hold%0d: got %b want 1010", i, {bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}); end
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_high: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        total++; if ({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor} !== 4'b1110) begin bad++; $display("FAIL bp_release: got %b want 1110", {bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        beat(32'hFFFF_FFFF, 1'b1);
        total++; if ({bus.out_valid, bus.out_and} !== 2'b11) begin bad++; $display("FAIL b2b_first: got %b want 11", {bus.out_valid, bus.out_and}); end
        bus.out_ready = 1'b1;
        beat(32'h0000_0000, 1'b1);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", bus.out_valid); end
        total++; if ({bus.out_and, bus.out_or, bus.out_xor, bus.out_nand, bus.out_nor, bus.out_xnor} !== 6'b000111) begin bad++; $display("FAIL b2b_flags: got %b want 000111", {bus.out_and, bus.out_or, bus.out_xor, bus.out_nand, bus.out_nor, bus.out_xnor}); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_gaps();
        beat(32'hFFFF_FFFF, 1'b0);
        bus.in_data = 32'h0000_0000;
        bus.in_last = 1'b1;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL gap_ignored: got %b want 0", bus.out_valid); end
        beat(32'hFFFF_FFFF, 1'b0);
        beat(32'hFFFF_FFFE, 1'b1);
        total++; if ({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor} !== 4'b1011) begin bad++; $display("FAIL gap_flags: got %b want 1011", {bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}); end
        step();
        beat(32'hFFFF_FFFF, 1'b0);
        beat(32'hFFFF_FFFF, 1'b0);
        beat(32'hFFFF_FFFF, 1'b1);
        total++; if ({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor} !== 4'b1110) begin bad++; $display("FAIL ones3_flags: got %b want 1110", {bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}); end
        step();
    endtask

    task automatic test_mid_frame_reset();
        bus.out_ready = 1'b0;
        beat(32'h0000_0001, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if ({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor} !== 4'b0100) begin bad++; $display("FAIL rst_pending: got %b want 0100", {bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}); end
        bus.out_ready = 1'b1;
        beat(32'h0000_0001, 1'b0);
        beat(32'h0000_0000, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if ({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor} !== 4'b0100) begin bad++; $display("FAIL rst_mid: got %b want 0100", {bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}); end
        beat(32'h8000_0000, 1'b1);
        total++; if ({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor} !== 4'b1011) begin bad++; $display("FAIL rst_next: got %b want 1011", {bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}); end
        step();
    endtask

`ifdef REDUCE_BEAT_COUNT_EN
    task automatic test_beat_count();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            beat(32'h0000_0000, (i == 299) ? 1'b1 : 1'b0);
        end
        total++; if (bus.out_beats !== 8'hFF) begin bad++; $display("FAIL cnt_sat: got %0d want 255", bus.out_beats); end
        step();
        beat(32'h0000_0000, 1'b0);
        beat(32'h0000_0000, 1'b0);
        beat(32'h0000_0000, 1'b1);
        total++; if (bus.out_beats !== 8'd3) begin bad++; $display("FAIL cnt_three: got %0d want 3", bus.out_beats); end
        step();
        beat(32'h0000_0000, 1'b1);
        total++; if (bus.out_beats !== 8'd1) begin bad++; $display("FAIL cnt_one: got %0d want 1", bus.out_beats); end
        step();
    endtask
`endif

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single_ones();
        test_two_beat();
        test_backpressure();
        test_back_to_back();
        test_gaps();
        test_mid_frame_reset();
`ifdef REDUCE_BEAT_COUNT_EN
        test_beat_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
